// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcm_pkg
// Brief    : Shared constants and types for the PCM serial path.
// Revision : 1.0 - initial release
// ============================================================================
package pcm_pkg;

    localparam int PCM_W           = 8;
    localparam int DEFAULT_CLK_DIV = 4;
    localparam int BIT_CNT_W       = $clog2(PCM_W + 1);

    // Action taken by the shifter on a bit-period boundary
    typedef enum logic [1:0] {
        SH_HOLD  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_LOAD  = 2'd2,
        SH_IDLE  = 2'd3
    } shift_op_e;

endpackage
`default_nettype wire

// File: rtl/pcm_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : pcm_bit_timer
// Brief    : Free-running clk divider; tick marks the last cycle of each
//            bit period.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_bit_timer
    import pcm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_CNT_W-1:0] div_cnt_q;
    logic [c_CNT_W-1:0] div_cnt_d;

    assign tick_o = (div_cnt_q == c_CNT_W'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1 and wrap
    always_comb begin
        div_cnt_d = tick_o ? '0 : div_cnt_q + c_CNT_W'(1);
    end

    // Divider register, runs regardless of stream enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pcm_serializer
// Brief    : Fetches 8-bit PCM samples through a one-deep prefetch buffer
//            and shifts them out as a gapless NRZ bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_serializer
    import pcm_pkg::*;
#(
    parameter int DATA_W    = PCM_W,
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output logic              sample_req,
    output logic              bit_out,
    output logic              bit_en,
    output logic              frame_start,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);

    // The buffer refill takes two cycles after a load, so a shorter bit
    // period could starve the next frame.
    if (CLK_DIV < 3) begin : g_clk_div_check
        $error("pcm_serializer: CLK_DIV must be 3 or more");
    end

    logic              tick;
    logic              req;
    shift_op_e         op;
    logic [DATA_W-1:0] shifted;

    logic [DATA_W-1:0]  buf_q, buf_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [c_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic               buf_full_q, buf_full_d;
    logic               req_pending_q, req_pending_d;
    logic               bit_out_q, bit_out_d;
    logic               frame_start_q, frame_start_d;
    logic               bit_en_q;

    pcm_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Request is combinational so the generator advances on the same edge
    // that arms the capture; gated by rst to keep it low during reset.
    assign req     = en & ~rst & ~buf_full_q & ~req_pending_q;
    assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Next-state: fetch/capture every cycle, shifter action on each tick
    always_comb begin
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        req_pending_d = req_pending_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        bit_out_d     = bit_out_q;
        frame_start_d = 1'b0;
        op            = SH_HOLD;

        if (req_pending_q) begin
            buf_d         = data_in;
            buf_full_d    = 1'b1;
            req_pending_d = 1'b0;
        end
        if (req) begin
            req_pending_d = 1'b1;
        end

        // Load decision uses buf_full from before this edge, so a capture
        // landing on a tick edge is kept for the following frame.
        if (tick) begin
            if (bit_cnt_q > c_CNT_W'(1)) begin
                op = SH_SHIFT;
            end else if (en && buf_full_q) begin
                op = SH_LOAD;
            end else begin
                op = SH_IDLE;
            end
        end

        case (op)
            SH_SHIFT: begin
                shreg_d   = shifted;
                bit_cnt_d = bit_cnt_q - c_CNT_W'(1);
                bit_out_d = MSB_FIRST ? shifted[DATA_W-1] : shifted[0];
            end
            SH_LOAD: begin
                shreg_d       = buf_q;
                bit_cnt_d     = c_CNT_W'(DATA_W);
                buf_full_d    = 1'b0;
                bit_out_d     = MSB_FIRST ? buf_q[DATA_W-1] : buf_q[0];
                frame_start_d = 1'b1;
            end
            SH_IDLE: begin
                bit_cnt_d = '0;
                bit_out_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q         <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            buf_full_q    <= 1'b0;
            req_pending_q <= 1'b0;
            bit_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            bit_en_q      <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            buf_full_q    <= buf_full_d;
            req_pending_q <= req_pending_d;
            bit_out_q     <= bit_out_d;
            frame_start_q <= frame_start_d;
            bit_en_q      <= tick;
        end
    end

    assign sample_req  = req;
    assign bit_out     = bit_out_q;
    assign bit_en      = bit_en_q;
    assign frame_start = frame_start_q;
    assign busy        = (bit_cnt_q != '0);

endmodule
`default_nettype wire
